fillscreen: RTL

FILLSCREEN -- requirements
Module: fillscreen

---
 rtl/fillscreen_pkg.sv | 14 +
 rtl/pixel_scan.sv | 53 +++++
 rtl/fillscreen.sv | 87 ++++++++
 3 files changed

// File: rtl/fillscreen_pkg.sv
// Shared screen geometry, coordinate widths and FSM state encoding
// for the fillscreen block.
package fillscreen_pkg;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int X_W = 8;
    localparam int Y_W = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/pixel_scan.sv
// Column-major x/y scan counters with enable, clear and last-pixel flag.
// The wrap on the final pixel returns both counters to zero.
module pixel_scan
    import fillscreen_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           clr,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);
    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            // y wraps and x steps in the same cycle
            if (y_q == Y_MAX) begin
                y_d = '0;
                x_d = (x_q == X_MAX) ? '0 : x_q + X_W'(1);
            end else begin
                y_d = y_q + Y_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);
endmodule

// File: rtl/fillscreen.sv
// Full-screen fill engine: plots one pixel per cycle, column-major,
// with solid colour or x mod 8 column stripes.
module fillscreen
    import fillscreen_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [2:0]     colour,
    output logic           done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot
);
    state_e         state_q, state_d;
    logic           mode_q, mode_d;
    logic [2:0]     colour_q, colour_d;
    logic           scan_en, scan_clr, scan_last;
    logic [X_W-1:0] scan_x;
    logic [Y_W-1:0] scan_y;
    logic           fill;

    pixel_scan #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) u_scan (
        .clk (clk),
        .rst (rst),
        .en  (scan_en),
        .clr (scan_clr),
        .x   (scan_x),
        .y   (scan_y),
        .last(scan_last)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        colour_d = colour_q;
        scan_en  = 1'b0;
        scan_clr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                scan_clr = 1'b1;
                if (start) begin
                    state_d  = S_FILL;
                    mode_d   = mode;
                    colour_d = colour;
                end
            end
            S_FILL: begin
                scan_en = 1'b1;
                if (scan_last) state_d = S_DONE;
            end
            S_DONE: begin
                scan_clr = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            colour_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            colour_q <= colour_d;
        end
    end

    // Outputs decode registered state only; start never reaches vga_plot.
    assign fill       = (state_q == S_FILL);
    assign vga_plot   = fill;
    assign done       = (state_q == S_DONE);
    assign vga_x      = fill ? scan_x : '0;
    assign vga_y      = fill ? scan_y : '0;
    assign vga_colour = !fill ? 3'd0 : (mode_q ? scan_x[2:0] : colour_q);
endmodule
